mem_port_arbiter: RTL and testbench

- Two-requester arbiter for the single-port block_ram: port A is the CPU memory path (address/write-data registers), port B is the program loader.
- Registers the winning request onto the RAM address/write bus and returns read data with a valid strobe to the winning requester.
- Round-robin arbitration, plus a loader lock that excludes the CPU while memory is being reprogrammed.

---
 rtl/mem_port_arbiter.sv | 76 +++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin CPU/loader arbiter for a single-port block RAM with loader lock
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  a_req,
    input  logic                  a_wen,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_wen,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic                  b_lock,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state;
    logic last_b, pend, pend_b, a_el, pick_b;
    assign a_el   = a_req & ~b_lock;
    assign pick_b = b_req & (~a_el | ~last_b);
    // Arbitrate in IDLE, hold the RAM access for one ISSUE cycle, return read data one cycle after the RAM output
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            pend      <= 1'b0;
            pend_b    <= 1'b0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            rdata     <= '0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            a_rvalid <= pend & ~pend_b;
            b_rvalid <= pend & pend_b;
            if (pend) rdata <= mem_rdata;
            if (state == ISSUE) begin
                state   <= IDLE;
                a_gnt   <= 1'b0;
                b_gnt   <= 1'b0;
                mem_wen <= 1'b0;
                busy    <= 1'b0;
                pend    <= ~mem_wen;
                pend_b  <= b_gnt;
            end else begin
                pend <= 1'b0;
                if (a_el | b_req) begin
                    state     <= ISSUE;
                    a_gnt     <= ~pick_b;
                    b_gnt     <= pick_b;
                    busy      <= 1'b1;
                    last_b    <= pick_b;
                    mem_wen   <= pick_b ? b_wen : a_wen;
                    mem_addr  <= pick_b ? b_addr : a_addr;
                    mem_wdata <= pick_b ? b_wdata : a_wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    logic        clk = 1'b0, a_reset_n = 1'b0;
    logic        a_req = 0, a_wen = 0, b_req = 0, b_wen = 0, b_lock = 0;
    logic [7:0]  a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_wen, busy;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] ram [256];
    logic [15:0] shadow [256];
    int tests = 0, fails = 0;
    logic        e_agnt, e_bgnt, e_arv, e_brv, e_wen, e_busy, last_was_b, ret_a, ret_b;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata, e_rdata, ret_data;

    mem_port_arbiter dut (
        .clk(clk), .a_reset_n(a_reset_n),
        .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        {e_agnt, e_bgnt, e_arv, e_brv, e_wen, e_busy, ret_a, ret_b} = '0;
        e_addr = 0; e_wdata = 0; e_rdata = 0; ret_data = 0;
        last_was_b = 1'b1;
    endtask

    task automatic model_tick();
        logic ae, pa;
        if (!a_reset_n) begin
            model_reset();
            return;
        end
        e_arv = ret_a;
        e_brv = ret_b;
        if (ret_a || ret_b) e_rdata = ret_data;
        ret_a = 0;
        ret_b = 0;
        if (e_busy) begin
            if (e_wen) shadow[e_addr] = e_wdata;
            else begin
                ret_a = e_agnt;
                ret_b = e_bgnt;
                ret_data = shadow[e_addr];
            end
            {e_agnt, e_bgnt, e_wen, e_busy} = '0;
        end else begin
            ae = a_req && !b_lock;
            if (ae || b_req) begin
                pa = ae && (!b_req || last_was_b);
                e_agnt = pa;
                e_bgnt = !pa;
                e_busy = 1;
                e_wen = pa ? a_wen : b_wen;
                e_addr = pa ? a_addr : b_addr;
                e_wdata = pa ? a_wdata : b_wdata;
                last_was_b = !pa;
            end
        end
    endtask

    task automatic check_all();
        chk("a_gnt", a_gnt, e_agnt);
        chk("b_gnt", b_gnt, e_bgnt);
        chk("a_rvalid", a_rvalid, e_arv);
        chk("b_rvalid", b_rvalid, e_brv);
        chk("mem_wen", mem_wen, e_wen);
        chk("busy", busy, e_busy);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("rdata", rdata, e_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_tick();
        check_all();
    endtask

    task automatic do_reset();
        a_reset_n = 0;
        #1;
        model_reset();
        chk("rst_outputs", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wen, busy, mem_addr, mem_wdata, rdata}, 0);
        check_all();
        step();
        step();
        @(negedge clk);
        a_reset_n = 1;
    endtask

    initial begin
        int n;
        logic got;
        logic [3:0] ord;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'($urandom);
            shadow[i] = ram[i];
        end
        ram[8'h10] = 16'hBEEF;
        shadow[8'h10] = 16'hBEEF;
        model_reset();
        do_reset();
        // single CPU read
        a_req = 1; a_wen = 0; a_addr = 8'h10;
        step();
        chk("t1_agnt", a_gnt, 1);
        chk("t1_addr", mem_addr, 8'h10);
        a_req = 0;
        step();
        step();
        chk("t1_rvalid", a_rvalid, 1);
        chk("t1_rdata", rdata, 16'hBEEF);
        // loader write then CPU read-back
        b_req = 1; b_wen = 1; b_addr = 8'h05; b_wdata = 16'h1234;
        step();
        chk("t2_wen", mem_wen, 1);
        b_req = 0;
        step();
        chk("t2_wen_off", mem_wen, 0);
        step();
        chk("t2_no_rvalid", b_rvalid, 0);
        a_req = 1; a_wen = 0; a_addr = 8'h05;
        step();
        a_req = 0;
        step();
        step();
        chk("t2_rdata", rdata, 16'h1234);
        // contention after reset
        do_reset();
        a_req = 1; a_wen = 0; a_addr = 8'h01;
        b_req = 1; b_wen = 0; b_addr = 8'h02;
        ord = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_gnt) ord = {ord[2:0], 1'b0};
            if (b_gnt) ord = {ord[2:0], 1'b1};
            chk("cont_both", a_gnt & b_gnt, 0);
        end
        chk("cont_order", ord, 4'b0101);
        a_req = 0; b_req = 0;
        repeat (3) step();
        // lock excludes CPU
        b_lock = 1; a_req = 1; a_wen = 0; a_addr = 8'h03;
        n = 0;
        repeat (10) begin
            step();
            n += int'(a_gnt) + int'(busy);
        end
        chk("lock_nogrant", n, 0);
        b_lock = 0;
        got = 0;
        for (int i = 0; i < 2 && !got; i++) begin
            step();
            got = a_gnt;
        end
        chk("lock_release", got, 1);
        a_req = 0;
        repeat (3) step();
        // reset during ISSUE of a CPU read
        a_req = 1; a_wen = 0; a_addr = 8'h07;
        step();
        chk("mid_gnt", a_gnt, 1);
        a_req = 0;
        do_reset();
        n = 0;
        repeat (3) begin
            step();
            n += int'(a_rvalid);
        end
        chk("mid_no_rvalid", n, 0);
        a_req = 1; b_req = 1; a_wen = 0; b_wen = 0;
        step();
        chk("mid_tie_a", a_gnt, 1);
        a_req = 0; b_req = 0;
        repeat (3) step();
        // withdrawn CPU request while loader holds the arbiter
        b_req = 1; b_wen = 0; b_addr = 8'h09;
        step();
        chk("wd_bgnt", b_gnt, 1);
        b_req = 0; a_req = 1;
        step();
        a_req = 0;
        n = 0;
        repeat (4) begin
            step();
            n += int'(a_gnt);
        end
        chk("wd_no_agnt", n, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!a_req || e_agnt) begin
                a_req = $urandom_range(0, 2) != 0;
                a_wen = 1'($urandom);
                a_addr = 8'($urandom_range(0, 31));
                a_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) a_req = 0;
            if (!b_req || e_bgnt) begin
                b_req = $urandom_range(0, 2) != 0;
                b_wen = 1'($urandom);
                b_addr = 8'($urandom_range(0, 31));
                b_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) b_req = 0;
            b_lock = $urandom_range(0, 7) == 0;
        end
        a_req = 0; b_req = 0; b_lock = 0;
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
